// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared types for the core's data-memory path.
//   - mem_size_t       : access size as encoded in funct3[1:0] of loads/stores
//   - mem_resp_state_t : control states of the data-memory responder
//   - mem_req_attr_t   : request attributes captured when a request is accepted
//   - extend_load()    : sign/zero extension of a byte or halfword load result
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_resp_state_t;

  typedef struct packed {
    logic      write;
    mem_size_t size;
    logic      is_unsigned;
  } mem_req_attr_t;

  // Extends a right-aligned byte (is_half=0) or halfword (is_half=1) to 32 bits.
  // Bits of raw above the selected width are ignored.
  function automatic logic [31:0] extend_load(input logic [15:0] raw,
                                              input logic        is_half,
                                              input logic        is_unsigned);
    logic [31:0] result;
    if (is_half) begin
      result = {{16{raw[15] & ~is_unsigned}}, raw};
    end else begin
      result = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
    end
    return result;
  endfunction

endpackage : core_pkg

// File: rtl/load_store_align.sv
// -----------------------------------------------------------------------------
// load_store_align
//   Purely combinational lane steering for one 32-bit data-memory access.
//   Ports:
//     size        in  2   access size (mem_size_t encoding)
//     is_unsigned in  1   zero-extend loads when 1
//     byte_off    in  2   byte offset within the word (addr[1:0])
//     wdata       in  32  store data, LSB-aligned
//     rdata_word  in  32  current contents of the addressed word
//     byte_en     out 4   lanes written by a store (0 for reserved size)
//     wdata_lane  out 32  store data replicated onto its byte lanes
//     load_data   out 32  extracted and extended load result
//     misaligned  out 1   halfword on odd address or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module load_store_align
  import core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Shift the addressed lane down to bit 0; halfwords use the 16-bit lane
  // boundary so an odd offset never mixes two halves into a good result.
  assign rd_byte = 8'(rdata_word >> {byte_off, 3'b000});
  assign rd_half = 16'(rdata_word >> {byte_off[1], 4'b0000});

  // NOTE: every output gets a default at the top of the block so no path
  // through the case leaves one unassigned (which would infer a latch).
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (mem_size_t'(size))
      MEM_BYTE: begin
        byte_en    = 4'b0001 << byte_off;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = extend_load({8'h00, rd_byte}, 1'b0, is_unsigned);
      end
      MEM_HALF: begin
        byte_en    = 4'b0011 << {byte_off[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        load_data  = extend_load(rd_half, 1'b1, is_unsigned);
        misaligned = byte_off[0];
      end
      MEM_WORD: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        load_data  = rdata_word;
        misaligned = (byte_off != 2'b00);
      end
      default: begin
        // Reserved size: no lanes, no data; the top flags it as an error.
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule : load_store_align

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Responder for the core's LSU data-memory port. Accepts one request at a
//   time, waits WAIT_STATES extra cycles, then performs the access on an
//   internal word-addressed array and presents a registered response until the
//   core takes it. Misaligned, out-of-range and reserved-size accesses return
//   rsp_error=1 with rsp_rdata=0 and leave the array untouched.
//   DATA_WIDTH must be 32; DEPTH_WORDS is expected to be a power of two with
//   ADDR_WIDTH >= clog2(DEPTH_WORDS)+2; WAIT_STATES is 0..15.
//   Ports:
//     clk           in   1           rising-edge clock
//     rst           in   1           synchronous reset, active-high
//     req_valid     in   1           request present
//     req_ready     out  1           idle and out of reset
//     req_write     in   1           1 = store, 0 = load
//     req_size      in   2           00 byte, 01 half, 10 word, 11 reserved
//     req_unsigned  in   1           zero-extend loads
//     req_addr      in   ADDR_WIDTH  byte address
//     req_wdata     in   DATA_WIDTH  store data, LSB-aligned
//     rsp_valid     out  1           response present
//     rsp_ready     in   1           core accepts the response
//     rsp_rdata     out  DATA_WIDTH  extended load data, 0 for stores/errors
//     rsp_error     out  1           access rejected
// -----------------------------------------------------------------------------
module data_memory_responder
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mem_resp_state_t       state;
  logic [3:0]            wait_cnt;
  mem_req_attr_t         lat_attr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Handshake and access qualification
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             access_go;
  logic             out_of_range;
  logic             size_rsvd;
  logic             access_error;
  logic             do_write;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;

  // req_ready looks at rst directly so the port reads 0 during the reset
  // cycle itself, not just from the edge after it.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The access happens on the edge that leaves WAIT.
  assign access_go = (state == WAIT) && (wait_cnt == 4'd0);

  assign word_idx     = lat_addr[IDX_W+1:2];
  assign out_of_range = (lat_addr[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);
  assign size_rsvd    = (lat_attr.size == MEM_RSVD);

  // Out-of-range reads are masked so the lane logic never sees stale data.
  assign rd_word = out_of_range ? '0 : mem[word_idx];

  // ---------------------------------------------------------------------------
  // Lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] load_data;
  logic        misaligned;

  load_store_align u_align (
    .size        (lat_attr.size),
    .is_unsigned (lat_attr.is_unsigned),
    .byte_off    (lat_addr[1:0]),
    .wdata       (lat_wdata),
    .rdata_word  (rd_word),
    .byte_en     (byte_en),
    .wdata_lane  (wdata_lane),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  assign access_error = size_rsvd || misaligned || out_of_range;

  // A store commits only on a clean WAIT->RESP edge; a reset on that same
  // edge discards it together with the response.
  assign do_write = access_go && lat_attr.write && !access_error && !rst;

  // ---------------------------------------------------------------------------
  // Request latch: req_* are looked at only on the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_attr.write       <= req_write;
      lat_attr.size        <= mem_size_t'(req_size);
      lat_attr.is_unsigned <= req_unsigned;
      lat_addr             <= req_addr;
      lat_wdata            <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // ---------------------------------------------------------------------------
  // NOTE: state and outputs are updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_error <= access_error;
            // Stores and rejected accesses return zero data.
            rsp_rdata <= (access_error || lat_attr.write) ? '0 : load_data;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          // Response data stays put until the core takes it; the next request
          // is accepted on a later edge since req_ready needs IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset; contents survive rst and the
  // array maps onto plain RAM with per-byte write enables.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byte_en[lane]) begin
          mem[word_idx][lane*8 +: 8] <= wdata_lane[lane*8 +: 8];
        end
      end
    end
  end

endmodule : data_memory_responder

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//   Byte-addressed reference model of the responder: a little-endian byte
//   array, per-request expected response and due cycle, and one monitor that
//   checks the handshake and response every cycle. Directed transactions pin
//   the model with literal values; randomized traffic exercises the rest.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_STATES = 1;
  localparam int MEM_BYTES   = 4 * DEPTH_WORDS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  always #5 clk = ~clk;

  data_memory_responder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] model_mem [MEM_BYTES];

  typedef struct {
    bit          write;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          due;
  } pend_t;

  pend_t pend;
  bit    have_pend = 1'b0;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_error(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    return (a >= 32'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] v;
    int          n;
    n = size_bytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[a + 32'(i)]) << (8 * i));
    // Two's-complement reinterpretation of an n-byte value.
    if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: expectations for every cycle, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  int ncyc     = 0;
  bit prev_rst = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      if (prev_rst) check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      have_pend = 1'b0;  // pending access and response are dropped
    end else if (!have_pend) begin
      check("idle_req_ready", 32'(req_ready), 32'd1);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      if (req_valid) begin
        pend.write = req_write;
        pend.size  = req_size;
        pend.uns   = req_unsigned;
        pend.addr  = req_addr;
        pend.wdata = req_wdata;
        pend.err   = model_error(req_size, req_addr);
        pend.rdata = (pend.err || req_write) ? 32'd0 : model_load(req_size, req_unsigned, req_addr);
        pend.due   = ncyc + WAIT_STATES + 2;
        have_pend  = 1'b1;
      end
    end else begin
      check("busy_req_ready", 32'(req_ready), 32'd0);
      if (ncyc < pend.due) begin
        check("early_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, pend.rdata);
        check("rsp_error", 32'(rsp_error), 32'(pend.err));
        if (rsp_ready) begin
          if (pend.write && !pend.err) begin
            for (int i = 0; i < size_bytes(pend.size); i++)
              model_mem[pend.addr + 32'(i)] = 8'(pend.wdata >> (8 * i));
          end
          have_pend = 1'b0;
        end
      end
    end
    prev_rst = rst;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic start_req(input bit w, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic wait_accept();
    int budget = 100;
    @(negedge clk);
    while (!req_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Request fields are scrambled after acceptance; the DUT must ignore them.
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er);
    int budget = 100;
    @(negedge clk);
    while (!rsp_valid && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!rsp_valid) check("response_timeout", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  task automatic txn(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er);
    start_req(w, sz, u, a, d);
    wait_accept();
    rsp_ready = (hold == 0);
    wait_rsp(rd, er);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'($urandom);  // ignored while no response is pending
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Give the array defined contents.
    for (int w = 0; w < DEPTH_WORDS; w++) txn(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'd0, 0, rd, er);

    // Word store then load.
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_rdata", rd, 32'h0);
    check("sw_error", 32'(er), 32'd0);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    check("lw_error", 32'(er), 32'd0);

    // Byte store and sign/zero-extended loads.
    txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 0, rd, er);
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd, er);
    check("lb_0x13", rd, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd, er);
    check("lbu_0x13", rd, 32'h00000080);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("lw_after_sb", rd, 32'h80ADBEEF);
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, rd, er);
    check("lh_0x12", rd, 32'hFFFF80AD);
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, rd, er);
    check("lhu_0x12", rd, 32'h000080AD);

    // Error cases.
    txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, rd, er);
    check("lh_misaligned_err", 32'(er), 32'd1);
    check("lh_misaligned_rdata", rd, 32'h0);
    txn(1'b1, 2'b10, 1'b0, 32'h12, 32'h1, 0, rd, er);
    check("sw_misaligned_err", 32'(er), 32'd1);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("lw_unchanged", rd, 32'h80ADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, rd, er);
    check("lw_out_of_range_err", 32'(er), 32'd1);
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("reserved_size_err", 32'(er), 32'd1);
    check("reserved_size_rdata", rd, 32'h0);

    // Backpressure with a second request waiting behind the response.
    start_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_accept();
    rsp_ready = 1'b0;
    wait_rsp(rd, er);
    check("bp_first_rdata", rd, 32'h80ADBEEF);
    @(posedge clk);
    #1;
    start_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept();
    wait_rsp(rd, er);
    check("bp_second_rdata", rd, 32'h00000080);
    @(posedge clk);
    #1;

    // Reset while a store is waiting: the store must be discarded.
    start_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    wait_accept();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("rst_discard_rdata", rd, 32'h0);
    check("rst_discard_error", 32'(er), 32'd0);

    // Randomized traffic, concentrated on a small window so loads hit stores.
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      r  = $urandom_range(0, 15);
      if (r == 0)      a = 32'($urandom_range(MEM_BYTES, MEM_BYTES + 64));
      else if (r == 1) a = $urandom;
      else if (r < 5)  a = 32'($urandom_range(0, MEM_BYTES - 1));
      else             a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
      end
      txn(1'($urandom), sz, 1'($urandom), a, $urandom,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_data_memory_responder
